// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op encodings, widths and bit-reverse helper for the shift execution stage
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int SHA_W  = 5;

    typedef enum logic [1:0] {
        SHOP_SRL = 2'b00,
        SHOP_SRA = 2'b01,
        SHOP_SLL = 2'b10,
        SHOP_ROR = 2'b11
    } shop_e;

    // Mirror a word end-for-end so a left shift can reuse the right-shift core
    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/log_right_shift_fill.sv
// rtl/log_right_shift_fill.sv - combinational 32-bit five-level logarithmic right shifter with fill bit
module log_right_shift_fill
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [SHA_W-1:0]  sha,
    input  logic              fill,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] stage [0:SHA_W];

    assign stage[0] = data;

    // Level i shifts by 2**i when sha[i] is set, feeding the fill bit in at the top
    for (genvar i = 0; i < SHA_W; i++) begin : g_lvl
        localparam int S = 1 << i;
        assign stage[i+1] = sha[i] ? {{S{fill}}, stage[i][DATA_W-1:S]} : stage[i];
    end

    assign result = stage[SHA_W];

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - two-stage SRL/SRA/SLL execution unit; SHIFT_EXEC_ROTATE_EN adds op 11 rotate-right
module shift_exec_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_sha,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    import shift_pkg::*;

    logic              s1_valid;
    shop_e             s1_op;
    logic [DATA_W-1:0] s1_data;
    logic [4:0]        s1_sha;
    logic [TAG_W-1:0]  s1_tag;

    logic              s2_adv;
    logic              s1_adv;
    logic              accept;
    logic [DATA_W-1:0] shift_res;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;
    assign busy     = s1_valid || out_valid;

`ifdef SHIFT_EXEC_ROTATE_EN
    // Parallel paths: right shifter on the operand, left shifter on the reversed operand;
    // rotate ORs the right shift by sha with the left shift by (32 - sha) mod 32.
    logic [DATA_W-1:0] rsh_out;
    logic [DATA_W-1:0] lsh_rev;
    logic [DATA_W-1:0] lsh_out;
    logic [4:0]        lsh_amt;
    logic              rsh_fill;

    assign rsh_fill = (s1_op == SHOP_SRA) && s1_data[DATA_W-1];
    assign lsh_amt  = (s1_op == SHOP_ROR) ? (5'd0 - s1_sha) : s1_sha;
    assign lsh_out  = bit_rev(lsh_rev);

    log_right_shift_fill u_rsh (
        .data   (s1_data),
        .sha    (s1_sha),
        .fill   (rsh_fill),
        .result (rsh_out)
    );

    log_right_shift_fill u_lsh (
        .data   (bit_rev(s1_data)),
        .sha    (lsh_amt),
        .fill   (1'b0),
        .result (lsh_rev)
    );

    // Select the result for the op held in S1
    always_comb begin
        shift_res = '0;
        case (s1_op)
            SHOP_SRL, SHOP_SRA: shift_res = rsh_out;
            SHOP_SLL:           shift_res = lsh_out;
            SHOP_ROR:           shift_res = rsh_out | lsh_out;
            default:            shift_res = '0;
        endcase
    end
`else
    // Single shared right shifter; left shifts go through it reversed on both sides
    logic [DATA_W-1:0] core_in;
    logic [DATA_W-1:0] core_out;
    logic              core_fill;

    assign core_in   = (s1_op == SHOP_SLL) ? bit_rev(s1_data) : s1_data;
    assign core_fill = (s1_op == SHOP_SRA) && s1_data[DATA_W-1];

    log_right_shift_fill u_rsh (
        .data   (core_in),
        .sha    (s1_sha),
        .fill   (core_fill),
        .result (core_out)
    );

    // Select the result for the op held in S1; op 11 is illegal here and yields zero
    always_comb begin
        shift_res = '0;
        case (s1_op)
            SHOP_SRL, SHOP_SRA: shift_res = core_out;
            SHOP_SLL:           shift_res = bit_rev(core_out);
            default:            shift_res = '0;
        endcase
    end
`endif

    // Stage 1: capture the issued op; empties when its op moves on and nothing replaces it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= SHOP_SRL;
            s1_data  <= '0;
            s1_sha   <= '0;
            s1_tag   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= shop_e'(in_op);
            s1_data  <= in_data;
            s1_sha   <= in_sha;
            s1_tag   <= in_tag;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: register the shifted result; frozen while writeback stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= shift_res;
                out_tag  <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - randomized self-checking bench for shift_exec_stage
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_sha;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        busy;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pop_cnt = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    bit   rand_bp = 0;

    always #5 clk = ~clk;

    shift_exec_stage #(.DATA_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_sha    (in_sha),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        case (op)
            2'd0:    return d >> s;
            2'd1:    return 32'($signed(d) >>> s);
            2'd2:    return d << s;
            default: begin
`ifdef SHIFT_EXEC_ROTATE_EN
                logic [63:0] dd;
                dd = {d, d} >> s;
                return dd[31:0];
`else
                return 32'd0;
`endif
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: retire results on output handshakes, queue expectations on accepts
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_tag", out_tag, e.t);
                end
                if (pop_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                pop_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.d = model(in_op, in_data, in_sha);
                n.t = in_tag;
                sb.push_back(n);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s, input logic [4:0] t);
        int n;
        bit acc;
        in_valid = 1'b1;
        in_op = op;
        in_data = d;
        in_sha = s;
        in_tag = t;
        n = 0;
        acc = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        rand_bp = 0;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", (sb.size() == 0 && !out_valid), 1);
    endtask

    logic [1:0]  t_op [0:7];
    logic [31:0] t_d  [0:7];
    logic [4:0]  t_s  [0:7];
    logic [31:0] t_e  [0:7];

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = 2'd0;
        in_data = '0;
        in_sha = '0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);

        // Latency: result appears two edges after the op is offered
        send(2'd0, 32'h8000_0000, 5'd4, 5'd3);
        chk("lat_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 32'h0800_0000);
        chk("lat_tag", out_tag, 3);
        drain();

        // Boundary table
        t_op[0] = 2'd1; t_d[0] = 32'h8000_0000; t_s[0] = 5'd31; t_e[0] = 32'hFFFF_FFFF;
        t_op[1] = 2'd1; t_d[1] = 32'h7FFF_FFFF; t_s[1] = 5'd31; t_e[1] = 32'h0000_0000;
        t_op[2] = 2'd2; t_d[2] = 32'h0000_0001; t_s[2] = 5'd31; t_e[2] = 32'h8000_0000;
        t_op[3] = 2'd0; t_d[3] = 32'h8000_0000; t_s[3] = 5'd31; t_e[3] = 32'h0000_0001;
        t_op[4] = 2'd0; t_d[4] = 32'hDEAD_BEEF; t_s[4] = 5'd0;  t_e[4] = 32'hDEAD_BEEF;
        t_op[5] = 2'd1; t_d[5] = 32'hDEAD_BEEF; t_s[5] = 5'd0;  t_e[5] = 32'hDEAD_BEEF;
        t_op[6] = 2'd2; t_d[6] = 32'hDEAD_BEEF; t_s[6] = 5'd0;  t_e[6] = 32'hDEAD_BEEF;
        t_op[7] = 2'd3; t_d[7] = 32'h0000_00F1; t_s[7] = 5'd4;
`ifdef SHIFT_EXEC_ROTATE_EN
        t_e[7] = 32'h1000_000F;
`else
        t_e[7] = 32'h0000_0000;
`endif
        for (int i = 0; i < 8; i++) begin
            send(t_op[i], t_d[i], t_s[i], 5'(i + 16));
            @(posedge clk);
            #1;
            chk("bnd_valid", out_valid, 1);
            chk($sformatf("bnd_data_%0d", i), out_data, t_e[i]);
            drain();
        end

        // Back-to-back stream of 8 ops
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            send(2'($urandom_range(0, 3)), $urandom, 5'($urandom), 5'(i));
        end
        drain();
        chk("b2b_count", pop_cnt, 8);
        chk("b2b_span", last_cyc - first_cyc, 7);

        // Backpressure: A in S2, B in S1, C refused
        pop_cnt = 0;
        out_ready = 1'b0;
        send(2'd0, 32'hF0F0_0000, 5'd8, 5'd10);
        send(2'd2, 32'h0000_0001, 5'd5, 5'd11);
        in_valid = 1'b1;
        in_op = 2'd1;
        in_data = 32'h8000_0000;
        in_sha = 5'd1;
        in_tag = 5'd12;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data_hold", out_data, 32'h00F0_F000);
            chk("bp_tag_hold", out_tag, 10);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_depth", sb.size(), 2);
        end
        out_ready = 1'b1;
        send(2'd1, 32'h8000_0000, 5'd1, 5'd12);
        drain();
        chk("bp_count", pop_cnt, 3);

        // Randomized traffic with random backpressure and gaps
        for (int i = 0; i < 150; i++) begin
            logic [4:0] s;
            case ($urandom_range(0, 3))
                0: s = 5'd0;
                1: s = 5'd31;
                default: s = 5'($urandom);
            endcase
            rand_bp = 1;
            send(2'($urandom_range(0, 3)), $urandom, s, 5'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        drain();

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(2'd0, 32'h1234_5678, 5'd4, 5'd1);
        send(2'd2, 32'h1234_5678, 5'd4, 5'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_tag", out_tag, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        pop_cnt = 0;
        @(posedge clk);
        #1;
        chk("arst_in_ready", in_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_stale", pop_cnt, 0);
        chk("arst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
